// File: rtl/sprite_position_renderer.sv
// Latches signed movement offsets once per frame, clamps the sprite rectangle to the
// visible area, reports its four edges and flags scan pixels that fall inside it.
module sprite_position_renderer #(
    parameter int SPRITE_H = 8,
    parameter int SPRITE_W = 8,
    parameter int BASE_ROW = 236,
    parameter int BASE_COL = 316,
    parameter int V_ACTIVE = 480,
    parameter int H_ACTIVE = 640,
    parameter int PW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] row_offset,
    input  logic [PW-1:0] column_offset,
    input  logic          frame_start,
    input  logic          video_on,
    input  logic [PW-1:0] pixel_row,
    input  logic [PW-1:0] pixel_column,
    output logic [PW-1:0] pixel1_row_pos,
    output logic [PW-1:0] pixel2_row_pos,
    output logic [PW-1:0] pixel3_column_pos,
    output logic [PW-1:0] pixel4_column_pos,
    output logic          sprite_on,
    output logic          offset_clamped,
    output logic          pos_valid
);

    typedef enum logic [1:0] {IDLE, LATCH, CLAMP, ACTIVE} state_t;

    localparam logic signed [PW:0] BASE_ROW_S = (PW+1)'(BASE_ROW);
    localparam logic signed [PW:0] BASE_COL_S = (PW+1)'(BASE_COL);
    localparam logic signed [PW:0] ROW_MAX    = (PW+1)'(V_ACTIVE - SPRITE_H);
    localparam logic signed [PW:0] COL_MAX    = (PW+1)'(H_ACTIVE - SPRITE_W);
    localparam logic [PW-1:0]      ROW_SPAN   = PW'(SPRITE_H - 1);
    localparam logic [PW-1:0]      COL_SPAN   = PW'(SPRITE_W - 1);
    localparam logic [PW-1:0]      TOP_RESET  = PW'(BASE_ROW);
    localparam logic [PW-1:0]      LEFT_RESET = PW'(BASE_COL);

    state_t            state;
    logic [PW-1:0]     row_shadow;
    logic [PW-1:0]     column_shadow;
    logic signed [PW:0] row_ext, column_ext;
    logic signed [PW:0] top_sum, left_sum;
    logic [PW-1:0]     top_next, left_next;
    logic              row_clip, column_clip;

    // One guard bit keeps BASE + most-negative offset from wrapping before the clamp.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        row_ext     = {row_shadow[PW-1], row_shadow};
        column_ext  = {column_shadow[PW-1], column_shadow};
        top_sum     = BASE_ROW_S + row_ext;
        left_sum    = BASE_COL_S + column_ext;
        top_next    = top_sum[PW-1:0];
        left_next   = left_sum[PW-1:0];
        row_clip    = 1'b0;
        column_clip = 1'b0;

        if (top_sum[PW]) begin
            top_next = '0;
            row_clip = 1'b1;
        end else if (top_sum > ROW_MAX) begin
            top_next = ROW_MAX[PW-1:0];
            row_clip = 1'b1;
        end

        if (left_sum[PW]) begin
            left_next   = '0;
            column_clip = 1'b1;
        end else if (left_sum > COL_MAX) begin
            left_next   = COL_MAX[PW-1:0];
            column_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            row_shadow        <= '0;
            column_shadow     <= '0;
            pixel1_row_pos    <= TOP_RESET;
            pixel2_row_pos    <= TOP_RESET + ROW_SPAN;
            pixel3_column_pos <= LEFT_RESET;
            pixel4_column_pos <= LEFT_RESET + COL_SPAN;
            sprite_on         <= 1'b0;
            offset_clamped    <= 1'b0;
            pos_valid         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE, ACTIVE: begin
                    if (frame_start) begin
                        row_shadow    <= row_offset;
                        column_shadow <= column_offset;
                        state         <= LATCH;
                    end
                end
                LATCH: state <= CLAMP;
                CLAMP: begin
                    pixel1_row_pos    <= top_next;
                    pixel2_row_pos    <= top_next + ROW_SPAN;
                    pixel3_column_pos <= left_next;
                    pixel4_column_pos <= left_next + COL_SPAN;
                    offset_clamped    <= row_clip | column_clip;
                    pos_valid         <= 1'b1;
                    state             <= ACTIVE;
                end
                default: state <= IDLE;
            endcase

            // Compares against the edges as registered before this edge.
            sprite_on <= video_on
                       && (pixel_row    >= pixel1_row_pos)    && (pixel_row    <= pixel2_row_pos)
                       && (pixel_column >= pixel3_column_pos) && (pixel_column <= pixel4_column_pos);
        end
    end

endmodule

// File: tb/tb_sprite_position_renderer.sv
// Randomised and directed checks of sprite_position_renderer against an arithmetic
// model of the clamped sprite rectangle.
module tb_sprite_position_renderer;

    localparam int PW = 11;
    localparam int OW = 4 * PW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW-1:0] row_offset = '0;
    logic [PW-1:0] column_offset = '0;
    logic          frame_start = 1'b0;
    logic          video_on = 1'b0;
    logic [PW-1:0] pixel_row = '0;
    logic [PW-1:0] pixel_column = '0;
    logic [PW-1:0] pixel1_row_pos, pixel2_row_pos, pixel3_column_pos, pixel4_column_pos;
    logic          sprite_on, offset_clamped, pos_valid;

    int errors = 0;
    int checks = 0;

    // Model state: the rectangle the bench believes is currently on screen.
    int exp_top = 236, exp_left = 316;

    sprite_position_renderer dut (
        .clk              (clk),
        .rst              (rst),
        .row_offset       (row_offset),
        .column_offset    (column_offset),
        .frame_start      (frame_start),
        .video_on         (video_on),
        .pixel_row        (pixel_row),
        .pixel_column     (pixel_column),
        .pixel1_row_pos   (pixel1_row_pos),
        .pixel2_row_pos   (pixel2_row_pos),
        .pixel3_column_pos(pixel3_column_pos),
        .pixel4_column_pos(pixel4_column_pos),
        .sprite_on        (sprite_on),
        .offset_clamped   (offset_clamped),
        .pos_valid        (pos_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] observed();
        return {pixel1_row_pos, pixel2_row_pos, pixel3_column_pos, pixel4_column_pos,
                offset_clamped, pos_valid};
    endfunction

    function automatic logic [OW-1:0] pack(int top, int left, bit clip, bit valid);
        return {PW'(top), PW'(top + 7), PW'(left), PW'(left + 7), clip, valid};
    endfunction

    // Screen-space rule: base + offset, held inside [0, active - size] on each axis.
    function automatic logic [OW-1:0] model(int r, int c);
        int  top  = 236 + r;
        int  left = 316 + c;
        bit  clip = 1'b0;
        if (top < 0)    begin top = 0;    clip = 1'b1; end
        if (top > 472)  begin top = 472;  clip = 1'b1; end
        if (left < 0)   begin left = 0;   clip = 1'b1; end
        if (left > 632) begin left = 632; clip = 1'b1; end
        exp_top  = top;
        exp_left = left;
        return pack(top, left, clip, 1'b1);
    endfunction

    function automatic bit model_on(int row, int col, bit vis);
        return vis && row >= exp_top && row <= exp_top + 7 && col >= exp_left && col <= exp_left + 7;
    endfunction

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(int r, int c);
        row_offset    = PW'(r);
        column_offset = PW'(c);
        frame_start   = 1'b1;
        tick();
        frame_start   = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        logic [OW-1:0] exp = pack(236, 316, 1'b0, 1'b0);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick();
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", observed(), exp);
        end
        checks++;
        if (sprite_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_sprite_on: got %b expected 0", sprite_on);
        end
    endtask

    task automatic test_basic_offset();
        logic [OW-1:0] exp = model(-10, 0);
        frame(-10, 0);
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("FAIL basic_offset: got %h expected %h", observed(), exp);
        end
    endtask

    task automatic test_clamp();
        int rows[4] = '{-300, -1024, 1023, 0};
        int cols[4] = '{400, -1024, 1023, 0};
        logic [OW-1:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = model(rows[i], cols[i]);
            frame(rows[i], cols[i]);
            checks++;
            if (observed() !== exp) begin
                errors++;
                $display("FAIL clamp_%0d (%0d,%0d): got %h expected %h",
                         i, rows[i], cols[i], observed(), exp);
            end
        end
        exp = pack(0, 632, 1'b1, 1'b1);
        frame(-300, 400);
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("FAIL clamp_corner: got %h expected %h", observed(), exp);
        end
    endtask

    task automatic test_no_tearing();
        logic [OW-1:0] exp = model(0, 0);
        frame(0, 0);
        row_offset    = PW'(50);
        column_offset = PW'(50);
        tick(1000);
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("FAIL no_tearing: got %h expected %h", observed(), exp);
        end
        exp = model(50, 50);
        frame(50, 50);
        checks++;
        if (observed() !== exp || pixel1_row_pos !== PW'(286) || pixel3_column_pos !== PW'(366)) begin
            errors++;
            $display("FAIL relatch_after_hold: got %h expected %h", observed(), exp);
        end
    endtask

    task automatic test_sprite_on();
        int  pr[5]  = '{226, 234, 226, 233, 226};
        int  pc[5]  = '{316, 316, 316, 323, 324};
        bit  vis[5] = '{1, 1, 0, 1, 1};
        bit  want[5] = '{1, 0, 0, 1, 0};
        frame(-10, 0);
        void'(model(-10, 0));
        for (int i = 0; i < 5; i++) begin
            pixel_row    = PW'(pr[i]);
            pixel_column = PW'(pc[i]);
            video_on     = vis[i];
            tick();
            checks++;
            if (sprite_on !== want[i]) begin
                errors++;
                $display("FAIL sprite_on_%0d (%0d,%0d,v=%0b): got %b expected %b",
                         i, pr[i], pc[i], vis[i], sprite_on, want[i]);
            end
        end
        video_on = 1'b0;
    endtask

    task automatic test_reset_mid_clamp();
        logic [OW-1:0] exp = pack(236, 316, 1'b0, 1'b0);
        row_offset    = PW'(100);
        column_offset = '0;
        frame_start   = 1'b1;
        tick();
        frame_start   = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (observed() !== exp || sprite_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_clamp: got %h expected %h", observed(), exp);
        end
        #2 rst = 1'b1;
        tick(5);
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("FAIL no_update_after_reset: got %h expected %h", observed(), exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] exp = model(5, 0);
        row_offset    = PW'(5);
        column_offset = '0;
        frame_start   = 1'b1;
        tick();
        row_offset    = PW'(9);
        tick();
        frame_start   = 1'b0;
        tick();
        checks++;
        if (observed() !== exp || pixel1_row_pos !== PW'(241)) begin
            errors++;
            $display("FAIL back_to_back: got %h expected %h", observed(), exp);
        end
        tick(3);
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("FAIL back_to_back_hold: got %h expected %h", observed(), exp);
        end
    endtask

    task automatic test_random();
        int r, c, row, col;
        bit vis;
        logic [OW-1:0] exp;
        for (int i = 0; i < 40; i++) begin
            r = $signed(PW'($urandom_range(0, 2047)));
            c = $signed(PW'($urandom_range(0, 2047)));
            if (i % 8 == 0) r = -1024;
            if (i % 8 == 1) c = 1023;
            exp = model(r, c);
            frame(r, c);
            checks++;
            if (observed() !== exp) begin
                errors++;
                $display("FAIL random_frame_%0d (%0d,%0d): got %h expected %h", i, r, c, observed(), exp);
            end
            row_offset    = PW'($urandom);
            column_offset = PW'($urandom);
            for (int k = 0; k < 6; k++) begin
                row = exp_top + $urandom_range(0, 11) - 2;
                col = exp_left + $urandom_range(0, 11) - 2;
                if (row < 0) row = 0;
                if (col < 0) col = 0;
                vis = ($urandom_range(0, 3) != 0);
                pixel_row    = PW'(row);
                pixel_column = PW'(col);
                video_on     = vis;
                tick();
                checks++;
                if (sprite_on !== model_on(row, col, vis)) begin
                    errors++;
                    $display("FAIL random_sprite_on_%0d_%0d (%0d,%0d,v=%0b): got %b expected %b",
                             i, k, row, col, vis, sprite_on, model_on(row, col, vis));
                end
            end
            checks++;
            if (observed() !== exp) begin
                errors++;
                $display("FAIL random_hold_%0d: got %h expected %h", i, observed(), exp);
            end
        end
        video_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_offset();
        test_clamp();
        test_no_tearing();
        test_sprite_on();
        test_reset_mid_clamp();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_position_renderer.md
Name: sprite_position_renderer

Overview:
Consumer end of the movement-offset interface. Takes signed row/column offsets from the keypad-driven offset controller and latches them once per frame. Turns them into a clamped on-screen sprite rectangle, returns the four edge positions to the offset controller for edge detection, and drives a registered sprite_on pixel flag into the VGA colour path.

Parameters:
SPRITE_H, 8, sprite height in lines
SPRITE_W, 8, sprite width in pixels
BASE_ROW, 236, top row at zero offset
BASE_COL, 316, left column at zero offset
V_ACTIVE, 480, visible lines
H_ACTIVE, 640, visible pixels per line
PW, 11, width of all position/offset buses (offsets are two's complement)

Ports:
clk  in  1  system pixel clock
rst  in  1  asynchronous active-low reset
row_offset  in  PW  signed vertical offset (negative = up)
column_offset  in  PW  signed horizontal offset (negative = left)
frame_start  in  1  one-cycle pulse at start of vertical blanking
video_on  in  1  current pixel is in the visible area
pixel_row  in  PW  current scan row, unsigned
pixel_column  in  PW  current scan column, unsigned
pixel1_row_pos  out  PW  sprite top row
pixel2_row_pos  out  PW  sprite bottom row (top + SPRITE_H - 1)
pixel3_column_pos  out  PW  sprite left column
pixel4_column_pos  out  PW  sprite right column (left + SPRITE_W - 1)
sprite_on  out  1  current scan pixel lies inside the sprite
offset_clamped  out  1  last latched offset drove the sprite past a screen edge
pos_valid  out  1  edge positions reflect at least one latched offset

Behaviour:
- Reset (rst low, asynchronous): FSM = IDLE
  - pixel1 = BASE_ROW, pixel2 = BASE_ROW+SPRITE_H-1
  - pixel3 = BASE_COL, pixel4 = BASE_COL+SPRITE_W-1
  - sprite_on = 0, offset_clamped = 0, pos_valid = 0, shadow offset regs = 0
- FSM states and transitions:
  - IDLE: wait for frame_start.
  - LATCH: entered the cycle after frame_start is sampled high. Captures row_offset/column_offset into shadow regs on that sampling edge.
  - CLAMP: computes and registers the new positions.
  - ACTIVE: holds positions; frame_start -> LATCH.
  - Sequence is IDLE/ACTIVE -(frame_start)-> LATCH -> CLAMP -> ACTIVE.
- Latency: frame_start sampled at edge N; edge outputs, offset_clamped and pos_valid update at edge N+2. pos_valid then stays 1 until reset.
- frame_start during LATCH or CLAMP is ignored. No re-latch until back in ACTIVE.
- Offset changes between frame_start pulses do not affect the outputs (no mid-frame tearing).
- Arithmetic:
  - Sign-extend BASE and offset to PW+1 bits.
  - top = BASE_ROW + row_offset_shadow; clamp to [0, V_ACTIVE-SPRITE_H].
  - left = BASE_COL + column_offset_shadow; clamp to [0, H_ACTIVE-SPRITE_W].
  - Bottom and right edges derive from the clamped values.
  - offset_clamped = 1 if either axis clamped, else 0. Held until the next CLAMP.
  - Offset -1024 (most negative) clamps to 0 with no wrap.
- sprite_on: registered, 1 cycle after pixel_row/pixel_column/video_on.
  - sprite_on = video_on AND pixel1 <= pixel_row <= pixel2 AND pixel3 <= pixel_column <= pixel4.
  - Uses the currently registered edges, including reset values while in IDLE.
- Reset mid-operation (in LATCH/CLAMP): abandons the update; outputs return to reset values immediately.

Test Plan:
1. Reset, then frame_start with offsets (-10, 0) -> two cycles later pixel1=226, pixel2=233, pixel3=316, pixel4=323, pos_valid=1, offset_clamped=0.
2. row_offset=-300, column_offset=+400, frame_start -> pixel1=0, pixel2=7, pixel3=632, pixel4=639, offset_clamped=1. Then offsets (0,0) with frame_start -> reset-position values, offset_clamped=0.
3. After a latch of (0,0), change offsets to (+50,+50) without frame_start for 1000 cycles -> edges unchanged. Next frame_start -> pixel1=286, pixel3=366.
4. Edges 226..233/316..323, drive pixel (226,316) with video_on=1 -> sprite_on=1 next cycle. Pixel (234,316) -> 0. Pixel (226,316) with video_on=0 -> 0.
5. Assert rst low during CLAMP after a frame_start with offset (+100,0) -> outputs immediately at reset values, pos_valid=0. No update after release until the next frame_start.
6. Pulse frame_start on two consecutive cycles with offsets (5,0) then (9,0) -> only (5,0) is latched: pixel1=241.
